ahbl_slave_decode_mux: RTL and testbench

- Slave-side decode and response stage of the AHB-Lite matrix.
- Address phase: decodes HADDR into one-hot slave selects, and raises the default-slave request for valid transfers to unmapped or disabled regions.
- Data phase: registers the selected target and multiplexes HRDATA/HREADY/HRESP back to the master.
- Consumes the default slave's ready/response outputs and logs the address of each faulting access.

---
 rtl/ahbl_slave_decode_mux_pkg.sv | 23 ++
 rtl/ahbl_slave_decode_mux_if.sv | 41 ++++
 rtl/ahbl_slave_decode_mux_addr_decode.sv | 28 ++
 rtl/ahbl_slave_decode_mux.sv | 88 ++++++++
 tb/tb_ahbl_slave_decode_mux.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/ahbl_slave_decode_mux_pkg.sv
// Shared AHB-Lite encodings and the data-phase target encoding used by the
// slave-side decode/response stage.
package ahbl_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam int NUM_SLOTS = 16;
    localparam int SLOT_MSB  = 31;
    localparam int SLOT_LSB  = 28;

    // Target encoding: 0..15 = slot, 16 = default slave, 31 = no transfer.
    typedef logic [4:0] sel_t;
    localparam sel_t SEL_DEFAULT = 5'd16;
    localparam sel_t SEL_NONE    = 5'd31;

    function automatic logic is_slot(input sel_t sel);
        return ~sel[4];
    endfunction

endpackage

// File: rtl/ahbl_slave_decode_mux_if.sv
// Bus bundle between the master side, the slaves and the decode/response stage.
// Handshake: a transfer is accepted when HTRANS[1]=1 and HREADY=1 at the clock
// edge; while HREADY=0 the master holds HADDR/HTRANS and all state is frozen.
interface ahbl_slave_decode_mux_if
    import ahbl_pkg::*;
#(
    parameter int DATA_WIDTH = 32
);
    logic [31:0]                     HADDR;
    logic [1:0]                      HTRANS;
    logic [NUM_SLOTS-1:0]            HSEL_S;
    logic [NUM_SLOTS-1:0]            HREADYOUT_S;
    logic [NUM_SLOTS-1:0]            HRESP_S;
    logic [NUM_SLOTS*DATA_WIDTH-1:0] HRDATA_S;
    logic                            DEFSLV_VALID;
    logic                            DEFSLV_HREADY;
    logic                            DEFSLV_HRESP;
    logic                            HREADY;
    logic                            HRESP;
    logic [DATA_WIDTH-1:0]           HRDATA;
    logic [31:0]                     ERR_ADDR;
    logic                            ERR_VALID;
    logic                            ERR_CLR;
    sel_t                            dp_sel;
    logic                            err_pend;

    modport slave (
        input  HADDR, HTRANS, HREADYOUT_S, HRESP_S, HRDATA_S,
               DEFSLV_HREADY, DEFSLV_HRESP, ERR_CLR,
        output HSEL_S, DEFSLV_VALID, HREADY, HRESP, HRDATA,
               ERR_ADDR, ERR_VALID, dp_sel, err_pend
    );

    modport master (
        output HADDR, HTRANS, HREADYOUT_S, HRESP_S, HRDATA_S,
               DEFSLV_HREADY, DEFSLV_HRESP, ERR_CLR,
        input  HSEL_S, DEFSLV_VALID, HREADY, HRESP, HRDATA,
               ERR_ADDR, ERR_VALID, dp_sel, err_pend
    );

endinterface

// File: rtl/ahbl_slave_decode_mux_addr_decode.sv
// Address-phase decode: one-hot slave select from the top address nibble and
// the address-phase target (slot, default slave or none).
module ahbl_addr_decode
    import ahbl_pkg::*;
#(
    parameter logic [NUM_SLOTS-1:0] SLAVE_EN = 16'hFFFF
) (
    input  logic [3:0]           slot,
    input  logic [1:0]           htrans,
    output logic [NUM_SLOTS-1:0] hsel,
    output sel_t                 ap_sel
);

    // HSEL is not gated by HTRANS; slaves qualify it themselves.
    always_comb begin
        hsel   = '0;
        ap_sel = SEL_NONE;
        if (SLAVE_EN[slot]) begin
            hsel[slot] = 1'b1;
        end
        case (htrans)
            HTRANS_NONSEQ, HTRANS_SEQ: ap_sel = SLAVE_EN[slot] ? {1'b0, slot} : SEL_DEFAULT;
            HTRANS_IDLE, HTRANS_BUSY:  ap_sel = SEL_NONE;
            default:                   ap_sel = SEL_NONE;
        endcase
    end

endmodule

// File: rtl/ahbl_slave_decode_mux.sv
// Slave-side decode and response stage: registers the data-phase target,
// muxes the slave responses back to the master and logs default-slave faults.
module ahbl_slave_decode_mux
    import ahbl_pkg::*;
#(
    parameter logic [NUM_SLOTS-1:0] SLAVE_EN   = 16'hFFFF,
    parameter int                   DATA_WIDTH = 32
) (
    input logic                    HCLK,
    input logic                    HRESETN,
    ahbl_slave_decode_mux_if.slave bus
);

    sel_t                  ap_sel;
    sel_t                  dp_sel;
    logic [NUM_SLOTS-1:0]  hsel;
    logic                  hready;
    logic                  hresp;
    logic [DATA_WIDTH-1:0] hrdata;
    logic [31:0]           err_addr;
    logic                  err_valid;
    logic                  err_pend;
    logic                  ap_default;
    logic                  dp_default_done;

    ahbl_addr_decode #(
        .SLAVE_EN (SLAVE_EN)
    ) u_decode (
        .slot   (bus.HADDR[SLOT_MSB:SLOT_LSB]),
        .htrans (bus.HTRANS),
        .hsel   (hsel),
        .ap_sel (ap_sel)
    );

    assign ap_default      = (ap_sel == SEL_DEFAULT);
    assign dp_default_done = (dp_sel == SEL_DEFAULT) && bus.DEFSLV_HREADY;

    always_comb begin
        hready = 1'b1;
        hresp  = 1'b0;
        hrdata = '0;
        if (dp_sel == SEL_DEFAULT) begin
            hready = bus.DEFSLV_HREADY;
            hresp  = bus.DEFSLV_HRESP;
        end else if (is_slot(dp_sel)) begin
            hready = bus.HREADYOUT_S[dp_sel[3:0]];
            hresp  = bus.HRESP_S[dp_sel[3:0]];
            hrdata = bus.HRDATA_S[dp_sel[3:0]*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // A new error set wins over ERR_CLR; a new default address phase wins over
    // clearing err_pend so back-to-back faults keep it raised.
    always_ff @(posedge HCLK or negedge HRESETN) begin
        if (!HRESETN) begin
            dp_sel    <= SEL_NONE;
            err_addr  <= '0;
            err_valid <= 1'b0;
            err_pend  <= 1'b0;
        end else begin
            if (hready) begin
                dp_sel <= ap_sel;
            end
            if (hready && ap_default) begin
                err_addr <= bus.HADDR;
                err_pend <= 1'b1;
            end else if (dp_default_done) begin
                err_pend <= 1'b0;
            end
            if (dp_default_done) begin
                err_valid <= 1'b1;
            end else if (bus.ERR_CLR) begin
                err_valid <= 1'b0;
            end
        end
    end

    assign bus.HSEL_S       = hsel;
    assign bus.DEFSLV_VALID = ap_default && hready;
    assign bus.HREADY       = hready;
    assign bus.HRESP        = hresp;
    assign bus.HRDATA       = hrdata;
    assign bus.ERR_ADDR     = err_addr;
    assign bus.ERR_VALID    = err_valid;
    assign bus.dp_sel       = dp_sel;
    assign bus.err_pend     = err_pend;

endmodule

// File: tb/tb_ahbl_slave_decode_mux.sv
// Directed bench for ahbl_slave_decode_mux with slots 0..7 enabled and
// slots 8..15 routed to the default slave.
module tb_ahbl_slave_decode_mux;
    import ahbl_pkg::*;

    localparam int DW = 32;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    ahbl_slave_decode_mux_if #(.DATA_WIDTH(DW)) bus ();

    ahbl_slave_decode_mux #(
        .SLAVE_EN   (16'h00FF),
        .DATA_WIDTH (DW)
    ) dut (
        .HCLK    (clk),
        .HRESETN (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus.HADDR         = '0;
        bus.HTRANS        = HTRANS_IDLE;
        bus.HREADYOUT_S   = '1;
        bus.HRESP_S       = '0;
        bus.DEFSLV_HREADY = 1'b1;
        bus.DEFSLV_HRESP  = 1'b0;
        bus.ERR_CLR       = 1'b0;
        for (int k = 0; k < NUM_SLOTS; k++) begin
            bus.HRDATA_S[k*DW +: DW] = 32'hCAFE_0000 | 32'(k);
        end

        // Reset values
        step();
        step();
        #1;
        chk("rst_hready", bus.HREADY, 1);
        chk("rst_hresp", bus.HRESP, 0);
        chk("rst_hrdata", bus.HRDATA, 0);
        chk("rst_err_valid", bus.ERR_VALID, 0);
        chk("rst_err_addr", bus.ERR_ADDR, 0);
        chk("rst_dp_sel", bus.dp_sel, 31);
        rst_n = 1'b1;

        // Normal read to slot 2 with two wait states
        step();
        bus.HADDR  = 32'h2000_0010;
        bus.HTRANS = HTRANS_NONSEQ;
        bus.HREADYOUT_S[2] = 1'b0;
        #1;
        chk("rd_hsel", bus.HSEL_S, 16'h0004);
        chk("rd_defslv_valid", bus.DEFSLV_VALID, 0);
        chk("rd_ap_hready", bus.HREADY, 1);
        step();
        bus.HTRANS = HTRANS_IDLE;
        #1;
        chk("rd_wait1_hready", bus.HREADY, 0);
        chk("rd_wait1_dp_sel", bus.dp_sel, 2);
        step();
        #1;
        chk("rd_wait2_hready", bus.HREADY, 0);
        chk("rd_wait2_dp_sel", bus.dp_sel, 2);
        step();
        bus.HREADYOUT_S[2] = 1'b1;
        #1;
        chk("rd_done_hready", bus.HREADY, 1);
        chk("rd_done_hrdata", bus.HRDATA, 32'hCAFE_0002);
        chk("rd_done_hresp", bus.HRESP, 0);
        step();
        #1;
        chk("rd_after_dp_sel", bus.dp_sel, 31);
        chk("rd_after_hrdata", bus.HRDATA, 0);

        // Unmapped access to slot 9, default slave errors with one wait state
        bus.HADDR  = 32'h9000_0004;
        bus.HTRANS = HTRANS_NONSEQ;
        bus.DEFSLV_HREADY = 1'b0;
        bus.DEFSLV_HRESP  = 1'b1;
        #1;
        chk("um_defslv_valid", bus.DEFSLV_VALID, 1);
        chk("um_hsel", bus.HSEL_S, 16'h0000);
        chk("um_ap_hready", bus.HREADY, 1);
        step();
        bus.HADDR  = 32'h9000_0000;
        bus.HTRANS = HTRANS_IDLE;
        #1;
        chk("um_wait_hready", bus.HREADY, 0);
        chk("um_wait_hresp", bus.HRESP, 1);
        chk("um_wait_err_addr", bus.ERR_ADDR, 32'h9000_0004);
        chk("um_wait_err_valid", bus.ERR_VALID, 0);
        chk("um_wait_err_pend", bus.err_pend, 1);
        chk("idle_um_defslv_valid", bus.DEFSLV_VALID, 0);
        step();
        bus.DEFSLV_HREADY = 1'b1;
        bus.ERR_CLR = 1'b1;
        #1;
        chk("um_done_hready", bus.HREADY, 1);
        chk("um_done_hresp", bus.HRESP, 1);
        chk("idle_um_defslv_valid2", bus.DEFSLV_VALID, 0);
        step();
        bus.ERR_CLR = 1'b0;
        bus.DEFSLV_HRESP = 1'b0;
        #1;
        chk("set_beats_clr_err_valid", bus.ERR_VALID, 1);
        chk("um_err_addr", bus.ERR_ADDR, 32'h9000_0004);
        chk("um_err_pend_clear", bus.err_pend, 0);
        chk("idle_um_hready", bus.HREADY, 1);
        chk("idle_um_hresp", bus.HRESP, 0);
        chk("idle_um_dp_sel", bus.dp_sel, 31);
        bus.ERR_CLR = 1'b1;
        step();
        bus.ERR_CLR = 1'b0;
        #1;
        chk("clr_err_valid", bus.ERR_VALID, 0);

        // Back-to-back default accesses keep the newest address
        bus.HADDR  = 32'hA000_0000;
        bus.HTRANS = HTRANS_NONSEQ;
        step();
        bus.HADDR  = 32'hF000_0008;
        bus.HTRANS = HTRANS_SEQ;
        #1;
        chk("b2b_defslv_valid", bus.DEFSLV_VALID, 1);
        chk("b2b_dp_sel", bus.dp_sel, 16);
        chk("b2b_first_err_addr", bus.ERR_ADDR, 32'hA000_0000);
        step();
        bus.HTRANS = HTRANS_IDLE;
        #1;
        chk("b2b_err_addr", bus.ERR_ADDR, 32'hF000_0008);
        chk("b2b_err_valid", bus.ERR_VALID, 1);
        step();

        // Pipeline stall: slot 3 waits while slot 5 address phase is pending
        bus.HADDR  = 32'h3000_0000;
        bus.HTRANS = HTRANS_NONSEQ;
        bus.HREADYOUT_S[3] = 1'b0;
        step();
        bus.HADDR = 32'h5000_0000;
        #1;
        chk("stall_hsel5", bus.HSEL_S, 16'h0020);
        chk("stall_hready", bus.HREADY, 0);
        chk("stall_dp_sel_a", bus.dp_sel, 3);
        step();
        #1;
        chk("stall_hsel5_held", bus.HSEL_S, 16'h0020);
        chk("stall_dp_sel_b", bus.dp_sel, 3);
        bus.HREADYOUT_S[3] = 1'b1;
        #1;
        chk("stall_release_hrdata", bus.HRDATA, 32'hCAFE_0003);
        step();
        bus.HTRANS = HTRANS_IDLE;
        #1;
        chk("stall_next_dp_sel", bus.dp_sel, 5);
        chk("stall_next_hrdata", bus.HRDATA, 32'hCAFE_0005);
        step();

        // Default request held low during a wait state, raised when HREADY rises
        bus.HADDR  = 32'h3000_0000;
        bus.HTRANS = HTRANS_NONSEQ;
        bus.HREADYOUT_S[3] = 1'b0;
        step();
        bus.HADDR = 32'hC000_0000;
        #1;
        chk("defwait_defslv_valid", bus.DEFSLV_VALID, 0);
        chk("defwait_hsel", bus.HSEL_S, 16'h0000);
        bus.HREADYOUT_S[3] = 1'b1;
        #1;
        chk("defrise_defslv_valid", bus.DEFSLV_VALID, 1);
        step();
        bus.HTRANS = HTRANS_IDLE;
        #1;
        chk("defrise_err_addr", bus.ERR_ADDR, 32'hC000_0000);
        chk("defrise_dp_sel", bus.dp_sel, 16);
        step();

        // Reset dropped during a slot-3 wait state
        bus.HADDR  = 32'h3000_0000;
        bus.HTRANS = HTRANS_NONSEQ;
        bus.HREADYOUT_S[3] = 1'b0;
        step();
        bus.HTRANS = HTRANS_IDLE;
        #1;
        chk("rstmid_pre_hready", bus.HREADY, 0);
        rst_n = 1'b0;
        #1;
        chk("rstmid_hready", bus.HREADY, 1);
        chk("rstmid_dp_sel", bus.dp_sel, 31);
        chk("rstmid_err_valid", bus.ERR_VALID, 0);
        chk("rstmid_err_addr", bus.ERR_ADDR, 0);
        step();
        rst_n = 1'b1;
        bus.HREADYOUT_S[3] = 1'b1;
        bus.HADDR  = 32'h4000_0000;
        bus.HTRANS = HTRANS_NONSEQ;
        #1;
        chk("post_rst_hsel", bus.HSEL_S, 16'h0010);
        step();
        bus.HTRANS = HTRANS_IDLE;
        #1;
        chk("post_rst_dp_sel", bus.dp_sel, 4);
        chk("post_rst_hrdata", bus.HRDATA, 32'hCAFE_0004);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
